// File: rtl/mem_store_monitor_if.sv
// Store-snoop bus between the core (master) and the self-check monitor (slave).
interface mem_store_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;

  modport master (output MemWrite, output ALUResult, output WriteData);
  modport slave  (input  MemWrite, input  ALUResult, input  WriteData);
endinterface

// File: rtl/mem_store_monitor.sv
// Self-check monitor: classifies core stores into PASS/FAIL, runs a cycle watchdog
// and keeps a circular log of the most recent stores for post-mortem readback.
module mem_store_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] ALLOW_ADDR     = 32'd96,
  parameter logic [31:0] ALLOW_MASK     = 32'hFFFF_FFFF,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000,
  parameter int unsigned LOG_DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  mem_store_if.slave                   bus,
  output logic                         done,
  output logic                         pass,
  output logic                         fail,
  output logic                         timeout,
  output logic [31:0]                  fail_addr,
  output logic [31:0]                  fail_data,
  output logic [15:0]                  store_count,
  output logic [31:0]                  cycle_count,
  input  logic [$clog2(LOG_DEPTH)-1:0] log_rd_idx,
  output logic                         log_rd_valid,
  output logic [31:0]                  log_rd_addr,
  output logic [31:0]                  log_rd_data
);

  localparam int unsigned IDX_W = $clog2(LOG_DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

  state_t             state, state_nxt;
  logic               store_en;
  logic [IDX_W-1:0]   wr_ptr;
  logic [IDX_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   log_count;
  logic [31:0]        log_addr [LOG_DEPTH];
  logic [31:0]        log_data [LOG_DEPTH];

  // A store is only acted on while running; bus contents are don't-care otherwise.
  assign store_en = (state == S_RUN) && bus.MemWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_nxt;
  end

  // Store verdict is evaluated after the watchdog so it takes precedence on a tie.
  always_comb begin
    state_nxt = state;
    if (state == S_RUN) begin
      if ((TIMEOUT_CYCLES != 32'd0) && (cycle_count == TIMEOUT_CYCLES - 32'd1))
        state_nxt = S_TIMEOUT;
      if (bus.MemWrite) begin
        if (bus.ALUResult == PASS_ADDR)
          state_nxt = (bus.WriteData == PASS_DATA) ? S_PASS : S_FAIL;
        else if ((bus.ALUResult & ALLOW_MASK) != (ALLOW_ADDR & ALLOW_MASK))
          state_nxt = S_FAIL;
      end
    end
  end

  // Registered verdicts, counters and offending-store capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      fail_addr   <= 32'd0;
      fail_data   <= 32'd0;
      store_count <= 16'd0;
      cycle_count <= 32'd0;
      wr_ptr      <= '0;
      log_count   <= '0;
    end else begin
      done    <= (state_nxt != S_RUN);
      pass    <= (state_nxt == S_PASS);
      fail    <= (state_nxt == S_FAIL);
      timeout <= (state_nxt == S_TIMEOUT);
      if (state == S_RUN) begin
        if (cycle_count != 32'hFFFF_FFFF) cycle_count <= cycle_count + 32'd1;
        if (state_nxt == S_FAIL) begin
          fail_addr <= bus.ALUResult;
          fail_data <= bus.WriteData;
        end
      end
      if (store_en) begin
        if (store_count != 16'hFFFF) store_count <= store_count + 16'd1;
        wr_ptr <= IDX_W'(wr_ptr + IDX_W'(1));
        if (log_count != CNT_W'(LOG_DEPTH)) log_count <= log_count + CNT_W'(1);
      end
    end
  end

  // Log storage needs no reset: entries are only exposed once written.
  always_ff @(posedge clk) begin
    if (rst && store_en) begin
      log_addr[wr_ptr] <= bus.ALUResult;
      log_data[wr_ptr] <= bus.WriteData;
    end
  end

  assign rd_ptr       = IDX_W'(wr_ptr - IDX_W'(1) - log_rd_idx);
  assign log_rd_valid = (CNT_W'(log_rd_idx) < log_count);
  assign log_rd_addr  = log_rd_valid ? log_addr[rd_ptr] : 32'd0;
  assign log_rd_data  = log_rd_valid ? log_data[rd_ptr] : 32'd0;

endmodule
